// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment controller.
// Segment encodings are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry n is the pattern for hex digit n (entry 0 is the rightmost element).
   localparam logic [15:0][6:0] HEX_SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// N-digit multiplexed seven-segment driver with refresh prescaler, PWM brightness,
// per-digit dp/blank and a pending/active buffer pair swapped at frame boundaries.
module seven_seg_display_ctrl
   import seven_seg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int PRESCALE_BITS = 17,
   parameter int BRIGHT_BITS   = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [4*DIGITS-1:0]      value,
   input  logic [DIGITS-1:0]        dp,
   input  logic [DIGITS-1:0]        blank,
   input  logic [BRIGHT_BITS-1:0]   brightness,
   input  logic                     load,
   output logic [DIGITS-1:0]        an,
   output logic [6:0]               seg,
   output logic                     dp_n,
   output logic                     frame_done
);

   localparam int IW = idx_width(DIGITS);

   logic [PRESCALE_BITS-1:0]  cnt_q, cnt_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [DIGITS-1:0][3:0]    pend_value_q, pend_value_d, act_value_q, act_value_d;
   logic [DIGITS-1:0]         pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [DIGITS-1:0]         pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
   logic [DIGITS-1:0]         an_q, an_d;
   logic [6:0]                seg_q, seg_d;
   logic                      dp_n_q, dp_n_d;
   logic                      frame_done_q, frame_done_d;

   logic                      tick, commit, lit;
   logic [6:0]                dec_seg;

   hex_to_seg u_dec (
      .nibble (act_value_q[idx_q]),
      .seg    (dec_seg)
   );

   always_comb begin
      tick   = &cnt_q;
      commit = tick && (idx_q == IW'(DIGITS - 1));
      cnt_d  = cnt_q + PRESCALE_BITS'(1);

      idx_d = idx_q;
      if (tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

      pend_value_d = load ? value : pend_value_q;
      pend_dp_d    = load ? dp    : pend_dp_q;
      pend_blank_d = load ? blank : pend_blank_q;

      // Active copies the pending contents from before this edge's load.
      act_value_d  = commit ? pend_value_q : act_value_q;
      act_dp_d     = commit ? pend_dp_q    : act_dp_q;
      act_blank_d  = commit ? pend_blank_q : act_blank_q;

      // PWM compares the top prescaler bits so the duty is spread over the slot.
      lit = !act_blank_q[idx_q] &&
            (cnt_q[PRESCALE_BITS-1 -: BRIGHT_BITS] <= brightness);

      an_d   = '1;
      seg_d  = SEG_BLANK;
      dp_n_d = 1'b1;
      if (lit) begin
         an_d[idx_q] = 1'b0;
         seg_d       = dec_seg;
         dp_n_d      = ~act_dp_q[idx_q];
      end
      frame_done_d = commit;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_value_q <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '1;
         act_value_q  <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '1;
         an_q         <= '1;
         seg_q        <= SEG_BLANK;
         dp_n_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_value_q <= pend_value_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         act_value_q  <= act_value_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_n_q       <= dp_n_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp_n       = dp_n_q;
   assign frame_done = frame_done_q;

endmodule
